// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply / divide unit.
//   op 00 MUL   : low WIDTH bits of a*b
//   op 01 MULHU : high WIDTH bits of a*b
//   op 10 DIVU  : floor(a/b)      (needs MULDIV_SEQ_DIV_EN)
//   op 11 REMU  : a mod b         (needs MULDIV_SEQ_DIV_EN)
// Optional feature macro: MULDIV_SEQ_DIV_EN enables the divide path. When it
// is undefined, divide ops complete in one edge with result 0.
// Handshake: start is sampled only in IDLE; busy is high during RUN; done is
// a one-cycle pulse in DONE, and result holds until the next DONE.
// One WIDTH+1-bit adder/subtractor is shared by every operation. The pair
// {r_acc, r_q} is the running product (multiply) or remainder/quotient (divide).
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_hi;        // result taken from r_acc (MULHU/REMU) else r_q
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;         // multiplicand or divisor
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
`ifdef MULDIV_SEQ_DIV_EN
  logic             r_div;
`endif

  logic             w_bypass;
  logic [WIDTH-1:0] w_bypass_result;
  logic             w_last;
  logic             w_sub;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_run_result;

  // Divide ops that need no iteration: divide-by-zero, or no divider present.
  always_comb begin
`ifdef MULDIV_SEQ_DIV_EN
    w_bypass        = op[1] && (b == '0);
    w_bypass_result = op[0] ? a : '1;
`else
    w_bypass        = op[1];
    w_bypass_result = '0;
`endif
  end

  assign w_last       = (r_cnt == LAST_STEP);
  assign w_run_result = r_hi ? w_step_acc : w_step_q;

  // Shared adder/subtractor plus the per-step shift for the active operation.
  always_comb begin
    w_sub   = 1'b0;
    w_add_a = {1'b0, r_acc};
    w_add_b = r_q[0] ? {1'b0, r_b} : '0;
`ifdef MULDIV_SEQ_DIV_EN
    if (r_div) begin
      w_sub   = 1'b1;
      w_add_a = {r_acc, r_q[WIDTH-1]};
      w_add_b = {1'b0, r_b};
    end
`endif
    w_sum = w_add_a + (w_add_b ^ {(WIDTH+1){w_sub}}) + {{WIDTH{1'b0}}, w_sub};
    // Multiply: add-if-lsb, then shift {carry, acc, q} right one place.
    w_step_acc = w_sum[WIDTH:1];
    w_step_q   = {w_sum[0], r_q[WIDTH-1:1]};
    // Divide: since the partial remainder < divisor, w_sum[WIDTH] is the borrow.
    if (w_sub) begin
      w_step_acc = w_sum[WIDTH] ? w_add_a[WIDTH-1:0] : w_sum[WIDTH-1:0];
      w_step_q   = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = w_bypass ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (r_state == S_RUN);
    done      = (r_state == S_DONE);
    dbg_state = r_state;
    result    = r_result;
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      r_div    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hi  <= op[0];
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= op[1] ? a : b;
            r_b   <= op[1] ? b : a;
`ifdef MULDIV_SEQ_DIV_EN
            r_div <= op[1];
`endif
            if (w_bypass) r_result <= w_bypass_result;
          end
        end
        S_RUN: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_result <= w_run_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq (WIDTH=32): vector table plus multi-cycle sequences.
// Honours MULDIV_SEQ_DIV_EN the same way as the design.
module tb_muldiv_seq;

`ifdef MULDIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int W = 32;
  localparam int MUL_LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // busy and done are mutually exclusive every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
    end
  end

  // reference model
  task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] mexp, output int mlat);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
    mlat = MUL_LAT;
    case (mop)
      2'b00: mexp = p[W-1:0];
      2'b01: mexp = p[2*W-1:W];
      default: begin
        if (!DIV_EN) begin
          mexp = '0; mlat = 1;
        end else if (mb == '0) begin
          mexp = mop[0] ? ma : '1; mlat = 1;
        end else begin
          mexp = mop[0] ? (ma % mb) : (ma / mb);
        end
      end
    endcase
  endtask

  // driver: called at a negedge with the DUT in IDLE; returns at a negedge in IDLE
  task automatic run_op(input logic [1:0] dop, input logic [W-1:0] da, input logic [W-1:0] db,
                        input logic [W-1:0] dexp, input int dlat, input string nm);
    int n;
    int nb;
    logic [W-1:0] e;
    start = 1'b1; op = dop; a = da; b = db;
    exp_q.push_back(dexp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    n = 1; nb = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (done === 1'b1) begin
      e = exp_q.pop_front();
      check({nm, "_result"}, result, e);
      check({nm, "_latency"}, W'(n), W'(dlat));
      check({nm, "_busy_cycles"}, W'(nb), W'(dlat - 1));
      @(negedge clk);
      check({nm, "_done_width"}, W'(done), W'(0));
      check({nm, "_result_hold"}, result, e);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no done after %0d edges expected %0d", nm, n, dlat);
      void'(exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int pulses;
    int first;
    int second;
    int cyc;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, rexp;
    int rlat;

    vecs[0] = '{2'b00, 32'd7,        32'd6,        32'h0000002A, MUL_LAT};
    vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT};
    vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[3] = '{2'b01, 32'h80000000, 32'd4,        32'h00000002, MUL_LAT};
    vecs[4] = '{2'b10, 32'd100, 32'd7, DIV_EN ? 32'h0000000E : 32'h0, DIV_EN ? MUL_LAT : 1};
    vecs[5] = '{2'b11, 32'd100, 32'd7, DIV_EN ? 32'h00000002 : 32'h0, DIV_EN ? MUL_LAT : 1};
    vecs[6] = '{2'b10, 32'd5,   32'd0, DIV_EN ? 32'hFFFFFFFF : 32'h0, 1};
    vecs[7] = '{2'b11, 32'd5,   32'd0, DIV_EN ? 32'h00000005 : 32'h0, 1};
    vecs[8] = '{2'b10, 32'hFFFFFFFF, 32'd1, DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_EN ? MUL_LAT : 1};
    vecs[9] = '{2'b11, 32'h12345678, 32'h00010000, DIV_EN ? 32'h00005678 : 32'h0, DIV_EN ? MUL_LAT : 1};

    // reset
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, '0);
    check("reset_state", W'(dbg_state), W'(0));
    rst_n = 1'b1;

    // table-driven vectors (first one accepted on the first edge after reset release)
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // random vectors against the model
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      model(rop, ra, rb, rexp, rlat);
      run_op(rop, ra, rb, rexp, rlat, $sformatf("rand%0d", i));
    end

    // start pulsed during RUN must be ignored
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) begin
        pulses++;
        check("ignore_start_result", result, 32'h0000000C);
      end
      @(negedge clk);
    end
    check("ignore_start_pulses", W'(pulses), W'(1));

    // start held high: new op every WIDTH+2 cycles
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    first = -1; second = -1; cyc = 0;
    while (second < 0 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        check("back_to_back_result", result, 32'd25);
        if (first < 0) first = cyc;
        else begin
          second = cyc;
          start = 1'b0;
        end
      end
    end
    check("back_to_back_first", W'(first), W'(MUL_LAT));
    check("back_to_back_period", W'(second - first), W'(W + 2));
    @(negedge clk);

    // reset mid-operation abandons the op
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", W'(busy), W'(0));
    check("midreset_done", W'(done), W'(0));
    check("midreset_result", result, '0);
    check("midreset_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'd2, 32'd3, 32'h00000006, MUL_LAT, "after_reset");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("after_reset_no_stray_done", W'(pulses), W'(0));

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The module SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port start  input  1  request to begin an operation, sampled only in IDLE.
REQ-005 The module SHALL have port op  input  2  operation select: 00 MUL (low WIDTH bits of a*b), 01 MULHU (high WIDTH bits, unsigned), 10 DIVU, 11 REMU.
REQ-006 The module SHALL have ports a, b  input  WIDTH  operands; a is multiplicand/dividend, b is multiplier/divisor.
REQ-007 The module SHALL have port busy  output  1  high while an accepted operation is iterating (state RUN).
REQ-008 The module SHALL have port done  output  1  single-cycle pulse marking result valid (state DONE).
REQ-009 The module SHALL have port result  output  WIDTH  outcome of the last completed operation.

Function
REQ-010 The controller SHALL implement states IDLE, RUN, DONE, with one shared WIDTH+1-bit adder/subtractor serving all ops.
REQ-011 In IDLE with start=1 on a rising edge, it SHALL latch op, a, b, clear the iteration counter, and go to RUN.
REQ-012 start SHALL be ignored in RUN and DONE; latched operands SHALL not change when inputs change.
REQ-013 RUN SHALL perform one shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU) step per cycle, for exactly WIDTH cycles.
REQ-014 After the WIDTH-th RUN cycle the controller SHALL enter DONE, loading result; DONE lasts exactly one cycle, then IDLE.
REQ-015 Latency SHALL be fixed: done is high in the cycle after the (WIDTH+1)-th rising edge following the accepting edge (33 edges for WIDTH=32).
REQ-016 Multiplication SHALL use a 2*WIDTH-bit unsigned product; MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
REQ-017 DIVU/REMU with b=0 SHALL bypass RUN: IDLE to DONE directly, result all-ones for DIVU and a for REMU, done one edge after acceptance.
REQ-018 DIVU/REMU with b!=0 SHALL yield floor(a/b) and a mod b respectively, unsigned.
REQ-019 result SHALL hold its value from DONE until the next entry to DONE; it SHALL not change during RUN.
REQ-020 busy and done SHALL never be high simultaneously; start held high continuously SHALL launch a new operation every WIDTH+2 cycles.
REQ-021 The iteration counter SHALL be ceil(log2(WIDTH))+1 bits and SHALL not wrap within an operation.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers=0.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-024 Reset release SHALL be synchronised externally; the block SHALL accept start on the first rising edge after rst_n rises.

Configuration
REQ-025 Macro MULDIV_SEQ_DIV_EN SHALL control the divide path.
REQ-026 With MULDIV_SEQ_DIV_EN defined, DIVU and REMU SHALL operate per REQ-013 to REQ-018.
REQ-027 Without it, divide logic SHALL be absent; op=10/11 SHALL go IDLE to DONE in one edge with result=0; MUL/MULHU unchanged.

Verification
REQ-028 MUL a=7 b=6 -> done 33 edges after accepting edge, result=0x0000002A, busy high exactly 32 cycles.
REQ-029 MUL and MULHU a=b=0xFFFFFFFF -> result 0x00000001 and 0xFFFFFFFE respectively.
REQ-030 DIVU and REMU a=100 b=7 -> result 0x0000000E and 0x00000002 (DIV_EN defined); both 0 with done after 1 edge (undefined).
REQ-031 DIVU and REMU a=5 b=0 -> done one edge after acceptance, result 0xFFFFFFFF and 0x00000005.
REQ-032 Start MUL 3*4, pulse start with op=00 a=9 b=9 during RUN -> ignored, result=0x0000000C, one done pulse only.
REQ-033 rst_n low for 1 cycle at RUN cycle 10 -> busy=0, done=0, result=0 immediately, no done pulse; next MUL 2*3 gives 0x00000006.
